// File: rtl/spart_buffered_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spart_buffered_if                                             |
// | Purpose  : CPU-side control/status bundle of the buffered SPART.         |
// |            iocs/iorw/ioaddr select the register access, rda/tbr report   |
// |            RX-data-available and TX-buffer-ready back to the CPU.        |
// |            The bidirectional databus stays a port of the UART itself     |
// |            so the tristate net is resolved at the module boundary.       |
// | Modports : master (CPU side), slave (UART side)                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface spart_buffered_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
  modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface
`default_nettype wire

// File: rtl/spart_buffered.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spart_buffered                                                |
// | Purpose  : CPU-addressable UART with TX/RX FIFOs, optional parity,       |
// |            sticky error flags and a programmable 16x baud divisor.       |
// | Ports    : clk, rst      - single clock, synchronous active-high reset   |
// |            bus (slave)   - iocs/iorw/ioaddr in, rda/tbr out              |
// |            databus       - bidirectional 8-bit CPU data bus              |
// |            txd / rxd     - serial out (idle high) / async serial in      |
// | Map      : 00 data, 01 status/clear, 10 divisor low, 11 divisor high     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module spart_buffered #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter logic [15:0] RESET_DIV  = 16'd325
) (
  input  wire logic       clk,
  input  wire logic       rst,
  spart_buffered_if.slave bus,
  inout  wire       [7:0] databus,
  output logic            txd,
  input  wire logic       rxd
);

  localparam int unsigned      c_AW       = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0]    c_PTR_ONE  = 1;
  localparam logic [2:0]       c_LAST_BIT = 3'(DATA_BITS - 1);

  localparam logic [2:0] c_S_IDLE   = 3'd0;
  localparam logic [2:0] c_S_START  = 3'd1;
  localparam logic [2:0] c_S_DATA   = 3'd2;
  localparam logic [2:0] c_S_PARITY = 3'd3;
  localparam logic [2:0] c_S_STOP   = 3'd4;

  // ---------------- bus decode ----------------
  logic w_rd_data, w_wr_data, w_rd_stat, w_wr_stat, w_wr_divl, w_wr_divh;
  assign w_rd_data = bus.iocs &&  bus.iorw && (bus.ioaddr == 2'b00);
  assign w_wr_data = bus.iocs && !bus.iorw && (bus.ioaddr == 2'b00);
  assign w_rd_stat = bus.iocs &&  bus.iorw && (bus.ioaddr == 2'b01);
  assign w_wr_stat = bus.iocs && !bus.iorw && (bus.ioaddr == 2'b01);
  assign w_wr_divl = bus.iocs && !bus.iorw && (bus.ioaddr == 2'b10);
  assign w_wr_divh = bus.iocs && !bus.iorw && (bus.ioaddr == 2'b11);

  // ---------------- baud generator ----------------
  logic [15:0] r_div;
  logic [15:0] r_baud_cnt;
  logic [7:0]  r_div_lo;
  logic        w_tick;
  assign w_tick = (r_baud_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div      <= RESET_DIV;
      r_baud_cnt <= RESET_DIV;
      r_div_lo   <= 8'h00;
    end else begin
      if (w_wr_divl) r_div_lo <= databus;
      // Committing the high byte restarts the tick period immediately.
      if (w_wr_divh) begin
        r_div      <= {databus, r_div_lo};
        r_baud_cnt <= {databus, r_div_lo};
      end else if (w_tick) begin
        r_baud_cnt <= r_div;
      end else begin
        r_baud_cnt <= r_baud_cnt - 16'd1;
      end
    end
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
  logic [c_AW:0]        r_tx_wr, r_tx_rd;
  logic                 w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
  logic [DATA_BITS-1:0] w_tx_head;

  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_full  = (r_tx_wr[c_AW] != r_tx_rd[c_AW]) &&
                      (r_tx_wr[c_AW-1:0] == r_tx_rd[c_AW-1:0]);
  assign w_tx_head  = r_tx_mem[r_tx_rd[c_AW-1:0]];
  // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
  assign w_tx_push  = w_wr_data && (!w_tx_full || w_tx_pop);

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[c_AW-1:0]] <= databus[DATA_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + c_PTR_ONE;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_PTR_ONE;
    end
  end

  // ---------------- TX FSM ----------------
  logic [2:0]           r_tx_state, w_tx_state_nxt;
  logic [3:0]           r_tx_tcnt;
  logic [2:0]           r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 w_txd;
  logic                 r_txd;
  logic                 w_tx_last_tick;
  logic                 w_tx_idle;

  assign w_tx_last_tick = w_tick && (r_tx_tcnt == 4'd15);
  assign w_tx_idle      = (r_tx_state == c_S_IDLE) && w_tx_empty;

  always_ff @(posedge clk) begin
    if (rst) r_tx_state <= c_S_IDLE;
    else     r_tx_state <= w_tx_state_nxt;
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    case (r_tx_state)
      c_S_IDLE:   if (w_tick && !w_tx_empty) w_tx_state_nxt = c_S_START;
      c_S_START:  if (w_tx_last_tick) w_tx_state_nxt = c_S_DATA;
      c_S_DATA:   if (w_tx_last_tick && (r_tx_bit == c_LAST_BIT))
                    w_tx_state_nxt = PARITY_EN ? c_S_PARITY : c_S_STOP;
      c_S_PARITY: if (w_tx_last_tick) w_tx_state_nxt = c_S_STOP;
      c_S_STOP:   if (w_tx_last_tick) w_tx_state_nxt = w_tx_empty ? c_S_IDLE : c_S_START;
      default:    w_tx_state_nxt = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_tx_pop = 1'b0;
    w_txd    = 1'b1;
    case (r_tx_state)
      c_S_IDLE:   w_tx_pop = w_tick && !w_tx_empty;
      c_S_START:  w_txd    = 1'b0;
      c_S_DATA:   w_txd    = r_tx_shift[0];
      c_S_PARITY: w_txd    = r_tx_par;
      c_S_STOP:   w_tx_pop = w_tx_last_tick && !w_tx_empty;
      default:    w_txd    = 1'b1;
    endcase
  end

  // Datapath: every pop loads a fresh frame; the tick counter wraps 15->0 at
  // each bit boundary so no explicit clear is needed between states.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_tcnt  <= 4'd0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_txd      <= 1'b1;
    end else begin
      r_txd <= w_txd;
      if (w_tx_pop) begin
        r_tx_shift <= w_tx_head;
        r_tx_par   <= (^w_tx_head) ^ PARITY_ODD;
        r_tx_tcnt  <= 4'd0;
        r_tx_bit   <= 3'd0;
      end else if (w_tick && (r_tx_state != c_S_IDLE)) begin
        r_tx_tcnt <= r_tx_tcnt + 4'd1;
        if ((r_tx_state == c_S_DATA) && (r_tx_tcnt == 4'd15)) begin
          r_tx_shift <= r_tx_shift >> 1;
          r_tx_bit   <= r_tx_bit + 3'd1;
        end
      end
    end
  end

  assign txd = r_txd;

  // ---------------- RX synchroniser + FSM ----------------
  logic [1:0] r_rx_sync;
  logic       w_rxs;
  assign w_rxs = r_rx_sync[1];

  always_ff @(posedge clk) begin
    if (rst) r_rx_sync <= 2'b11;
    else     r_rx_sync <= {r_rx_sync[0], rxd};
  end

  logic [2:0]           r_rx_state, w_rx_state_nxt;
  logic [3:0]           r_rx_tcnt;
  logic [2:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par;
  logic                 w_rx_mid, w_rx_push, w_rx_frame_err, w_rx_par_err;

  // Mid-bit sample point for every bit after START.
  assign w_rx_mid = w_tick && (r_rx_tcnt == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) r_rx_state <= c_S_IDLE;
    else     r_rx_state <= w_rx_state_nxt;
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      c_S_IDLE:   if (w_tick && !w_rxs) w_rx_state_nxt = c_S_START;
      // Half a bit later the line must still be low, else it was a glitch.
      c_S_START:  if (w_tick && (r_rx_tcnt == 4'd7))
                    w_rx_state_nxt = w_rxs ? c_S_IDLE : c_S_DATA;
      c_S_DATA:   if (w_rx_mid && (r_rx_bit == c_LAST_BIT))
                    w_rx_state_nxt = PARITY_EN ? c_S_PARITY : c_S_STOP;
      c_S_PARITY: if (w_rx_mid) w_rx_state_nxt = c_S_STOP;
      c_S_STOP:   if (w_rx_mid) w_rx_state_nxt = c_S_IDLE;
      default:    w_rx_state_nxt = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_rx_push      = 1'b0;
    w_rx_frame_err = 1'b0;
    w_rx_par_err   = 1'b0;
    if ((r_rx_state == c_S_STOP) && w_rx_mid) begin
      w_rx_push      = 1'b1;
      w_rx_frame_err = !w_rxs;
      w_rx_par_err   = PARITY_EN && (((^r_rx_shift) ^ r_rx_par) != PARITY_ODD);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_tcnt  <= 4'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
    end else if (r_rx_state == c_S_IDLE) begin
      r_rx_tcnt <= 4'd0;
      r_rx_bit  <= 3'd0;
    end else if (w_tick) begin
      if ((r_rx_state == c_S_START) && (r_rx_tcnt == 4'd7)) r_rx_tcnt <= 4'd0;
      else                                                  r_rx_tcnt <= r_rx_tcnt + 4'd1;
      if ((r_rx_state == c_S_DATA) && (r_rx_tcnt == 4'd15)) begin
        r_rx_shift <= {w_rxs, r_rx_shift[DATA_BITS-1:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end
      if ((r_rx_state == c_S_PARITY) && (r_rx_tcnt == 4'd15)) r_rx_par <= w_rxs;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
  logic [c_AW:0]        r_rx_wr, r_rx_rd;
  logic                 w_rx_empty, w_rx_full, w_rx_pop, w_rx_wr, w_rx_ovr;
  logic [DATA_BITS-1:0] w_rx_head;

  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[c_AW] != r_rx_rd[c_AW]) &&
                      (r_rx_wr[c_AW-1:0] == r_rx_rd[c_AW-1:0]);
  assign w_rx_head  = r_rx_mem[r_rx_rd[c_AW-1:0]];
  assign w_rx_pop   = w_rd_data && !w_rx_empty;
  assign w_rx_wr    = w_rx_push && (!w_rx_full || w_rx_pop);
  assign w_rx_ovr   = w_rx_push && w_rx_full && !w_rx_pop;

  always_ff @(posedge clk) begin
    if (w_rx_wr) r_rx_mem[r_rx_wr[c_AW-1:0]] <= r_rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      if (w_rx_wr)  r_rx_wr <= r_rx_wr + c_PTR_ONE;
      if (w_rx_pop) r_rx_rd <= r_rx_rd + c_PTR_ONE;
    end
  end

  // ---------------- status ----------------
  logic r_ovr, r_perr, r_ferr, r_rda, r_tbr;

  // A new error in the same cycle as a clear write is kept (set wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovr  <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_rda  <= 1'b0;
      r_tbr  <= 1'b1;
    end else begin
      r_rda <= !w_rx_empty;
      r_tbr <= !w_tx_full;
      if (w_wr_stat) begin
        r_ovr  <= 1'b0;
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
      end
      if (w_rx_ovr)                  r_ovr  <= 1'b1;
      if (w_rx_push && w_rx_par_err) r_perr <= 1'b1;
      if (w_rx_push && w_rx_frame_err) r_ferr <= 1'b1;
    end
  end

  assign bus.rda = r_rda;
  assign bus.tbr = r_tbr;

  // ---------------- read mux / bus drive ----------------
  logic [7:0] w_rdata;
  always_comb begin
    w_rdata = 8'h00;
    if (w_rd_stat)        w_rdata = {2'b00, w_tx_idle, r_ferr, r_perr, r_ovr, r_tbr, r_rda};
    else if (!w_rx_empty) w_rdata[DATA_BITS-1:0] = w_rx_head;
  end

  assign databus = (w_rd_data || w_rd_stat) ? w_rdata : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_spart_buffered.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_spart_buffered                                             |
// | Purpose  : Self-checking bench for spart_buffered. u_dut0 is the default |
// |            build (optionally looped txd->rxd), u_dut1 enables even       |
// |            parity. Expected bytes, waveforms and status words come from  |
// |            frame rules and queues kept here.                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_spart_buffered;
  localparam int BIT_CYC = 32;   // 16 ticks x (divisor 1 + 1)

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spart_buffered_if bus0 ();
  spart_buffered_if bus1 ();

  wire  [7:0] db0, db1;
  logic       drv0 = 1'b0, drv1 = 1'b0;
  logic [7:0] wd0 = 8'h00, wd1 = 8'h00;
  assign db0 = drv0 ? wd0 : 8'hzz;
  assign db1 = drv1 ? wd1 : 8'hzz;

  logic txd0, txd1;
  logic rx0_tb = 1'b1, rx1_tb = 1'b1, loop = 1'b0;
  wire  rxd0 = loop ? txd0 : rx0_tb;

  spart_buffered #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0),
                   .RESET_DIV(16'd325)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .databus(db0), .txd(txd0), .rxd(rxd0));

  spart_buffered #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0),
                   .RESET_DIV(16'd325)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .databus(db1), .txd(txd1), .rxd(rx1_tb));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle(input int sel);
    if (sel == 0) begin bus0.iocs = 1'b0; bus0.iorw = 1'b0; bus0.ioaddr = 2'b00; drv0 = 1'b0; end
    else          begin bus1.iocs = 1'b0; bus1.iorw = 1'b0; bus1.ioaddr = 2'b00; drv1 = 1'b0; end
  endtask

  task automatic bus_write(input int sel, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    if (sel == 0) begin bus0.iocs = 1'b1; bus0.iorw = 1'b0; bus0.ioaddr = a; wd0 = d; drv0 = 1'b1; end
    else          begin bus1.iocs = 1'b1; bus1.iorw = 1'b0; bus1.ioaddr = a; wd1 = d; drv1 = 1'b1; end
    @(posedge clk);
    #1 bus_idle(sel);
  endtask

  task automatic bus_read(input int sel, input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    if (sel == 0) begin bus0.iocs = 1'b1; bus0.iorw = 1'b1; bus0.ioaddr = a; end
    else          begin bus1.iocs = 1'b1; bus1.iorw = 1'b1; bus1.ioaddr = a; end
    #2 d = (sel == 0) ? db0 : db1;
    @(posedge clk);
    #1 bus_idle(sel);
  endtask

  task automatic set_div1(input int sel);
    bus_write(sel, 2'b10, 8'h01);
    bus_write(sel, 2'b11, 8'h00);
  endtask

  task automatic wait_txd0(input logic lvl, input int budget, output int n);
    n = 0;
    while (txd0 !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drive_rx(input int sel, input logic b, input int cyc);
    @(negedge clk);
    if (sel == 0) rx0_tb = b; else rx1_tb = b;
    repeat (cyc - 1) @(negedge clk);
  endtask

  // Frame with optional parity; a bad stop bit is held low for 3/4 of a bit.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic with_par,
                            input logic par_bit, input logic stop_ok);
    drive_rx(sel, 1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) drive_rx(sel, d[i], BIT_CYC);
    if (with_par) drive_rx(sel, par_bit, BIT_CYC);
    if (stop_ok) drive_rx(sel, 1'b1, BIT_CYC);
    else         drive_rx(sel, 1'b0, 24);
    drive_rx(sel, 1'b1, BIT_CYC);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] exp_b;
    logic [7:0] q [$];
    logic       cap [0:449];
    int         n, s, errs, div, budget, cyc;
    logic       eb;

    bus_idle(0);
    bus_idle(1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // ---- reset state ----
    check_val("rst_txd", txd0, 1);
    check_val("rst_rda", bus0.rda, 0);
    check_val("rst_tbr", bus0.tbr, 1);
    check_val("rst_txd1", txd1, 1);
    bus_read(0, 2'b01, d);
    check_val("rst_status", d, 8'h22);

    // ---- default divisor: start bit lasts 16 x 326 cycles ----
    bus_write(0, 2'b00, 8'h01);
    wait_txd0(1'b0, 400, n);
    check_val("dflt_start_seen", n < 400, 1);
    wait_txd0(1'b1, 6000, n);
    check_val("dflt_start_len", n, 16 * 326);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    set_div1(0);
    set_div1(1);

    // ---- TX waveform of 0xA5 at divisor 1 ----
    exp_b = 8'hA5;
    bus_write(0, 2'b00, exp_b);
    for (int i = 0; i < 450; i++) begin
      @(negedge clk);
      cap[i] = txd0;
    end
    s = 0;
    while (s < 40 && cap[s] !== 1'b0) s++;
    check_val("tx_start_found", s < 40, 1);
    if (s < 40) begin
      for (int k = 0; k < 10; k++) begin
        eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : exp_b[k-1];
        errs = 0;
        for (int j = 0; j < BIT_CYC; j++) if (cap[s + k*BIT_CYC + j] !== eb) errs++;
        check_val($sformatf("tx_bit%0d_bad_cycles", k), errs, 0);
      end
      errs = 0;
      for (int j = s + 10*BIT_CYC; j < 450; j++) if (cap[j] !== 1'b1) errs++;
      check_val("tx_after_frame_idle", errs, 0);
    end
    bus_read(0, 2'b01, d);
    check_val("tx_done_status", d, 8'h22);

    // ---- loopback with random bytes and divisors ----
    loop = 1'b1;
    for (int r = 0; r < 3; r++) begin
      div = (r == 0) ? 1 : int'($urandom_range(0, 3));
      bus_write(0, 2'b10, 8'(div));
      bus_write(0, 2'b11, 8'h00);
      q.delete();
      for (int i = 0; i < 5; i++) begin
        exp_b = 8'($urandom);
        q.push_back(exp_b);
        bus_write(0, 2'b00, exp_b);
      end
      if (r == 0) begin
        repeat (2) @(negedge clk);
        check_val("tbr_full", bus0.tbr, 0);
      end
      budget = 6 * 160 * (div + 1) + 500;
      cyc = 0;
      while (q.size() > 0 && cyc < budget) begin
        @(negedge clk);
        cyc++;
        if (bus0.rda) begin
          bus_read(0, 2'b00, d);
          check_val($sformatf("loop_r%0d_data", r), d, q.pop_front());
          repeat (2) @(negedge clk);
        end
      end
      check_val("loop_left_over", q.size(), 0);
      repeat (100) @(negedge clk);
      check_val("loop_rda_empty", bus0.rda, 0);
      bus_read(0, 2'b01, d);
      check_val("loop_status", d, 8'h22);
    end
    loop = 1'b0;
    set_div1(0);

    // ---- overrun: five frames, nothing read ----
    q.delete();
    for (int i = 0; i < 5; i++) begin
      exp_b = 8'($urandom);
      if (i < 4) q.push_back(exp_b);
      send_frame(0, exp_b, 1'b0, 1'b0, 1'b1);
    end
    bus_read(0, 2'b01, d);
    check_val("ovr_status", d, 8'h27);
    for (int i = 0; i < 4; i++) begin
      bus_read(0, 2'b00, d);
      check_val("ovr_data", d, q.pop_front());
    end
    repeat (2) @(negedge clk);
    bus_read(0, 2'b00, d);
    check_val("empty_read_zero", d, 8'h00);
    bus_write(0, 2'b01, 8'h00);
    bus_read(0, 2'b01, d);
    check_val("ovr_cleared", d, 8'h22);

    // ---- frame error: byte still delivered ----
    exp_b = 8'($urandom);
    send_frame(0, exp_b, 1'b0, 1'b0, 1'b0);
    repeat (BIT_CYC) @(negedge clk);
    bus_read(0, 2'b01, d);
    check_val("ferr_status", d, 8'h33);
    bus_read(0, 2'b00, d);
    check_val("ferr_data", d, exp_b);
    repeat (2) @(negedge clk);
    bus_write(0, 2'b01, 8'h00);
    bus_read(0, 2'b01, d);
    check_val("ferr_cleared", d, 8'h22);

    // ---- even parity on u_dut1 ----
    for (int i = 0; i < 2; i++) begin
      exp_b = 8'($urandom);
      send_frame(1, exp_b, 1'b1, ^exp_b, 1'b1);
      bus_read(1, 2'b00, d);
      check_val("par_good_data", d, exp_b);
      repeat (2) @(negedge clk);
      bus_read(1, 2'b01, d);
      check_val("par_good_status", d, 8'h22);
    end
    exp_b = 8'h03;
    send_frame(1, exp_b, 1'b1, 1'b1, 1'b1);
    bus_read(1, 2'b01, d);
    check_val("par_bad_status", d, 8'h2B);
    bus_read(1, 2'b00, d);
    check_val("par_bad_data", d, 8'h03);

    // ---- 4-tick glitch on rxd ----
    drive_rx(0, 1'b0, 8);
    drive_rx(0, 1'b1, 400);
    check_val("glitch_rda", bus0.rda, 0);
    bus_read(0, 2'b01, d);
    check_val("glitch_status", d, 8'h22);

    // ---- reset in the middle of a TX frame ----
    bus_write(0, 2'b00, 8'h00);
    bus_write(0, 2'b00, 8'h55);
    bus_write(0, 2'b00, 8'h66);
    repeat (100) @(negedge clk);
    check_val("tx_mid_low", txd0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 check_val("txd_after_rst", txd0, 1);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_mid_tbr", bus0.tbr, 1);
    check_val("rst_mid_rda", bus0.rda, 0);
    bus_read(0, 2'b01, d);
    check_val("rst_mid_status", d, 8'h22);
    errs = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (txd0 !== 1'b1) errs++;
    end
    check_val("no_tx_after_rst", errs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
